dma_row_reader: RTL and testbench

//   Read-side DMA, the counterpart of the row-writing DMA. On start, reads

---
 rtl/dma_row_reader.sv | 135 +++++++++++++
 tb/tb_dma_row_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_row_reader.sv
// Read-side row DMA: fetches rowSize/blockSize consecutive RAM words and packs them into one row.
// Optional DMA_RD_CHECKSUM_EN adds a checksum output (XOR of all captured blocks).
module dma_row_reader #(
    parameter int blockSize = 16,
    parameter int rowSize   = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dma_enable,
    input  logic [15:0]          base_address,
    output logic                 ram_enable,
    output logic                 write,
    output logic [15:0]          address,
    input  logic [blockSize-1:0] ram_data,
    output logic [rowSize-1:0]   row_out,
    output logic                 busy,
`ifdef DMA_RD_CHECKSUM_EN
    output logic [blockSize-1:0] checksum,
`endif
    output logic                 done
);

    localparam int NBLK  = rowSize / blockSize;
    localparam int CNT_W = $clog2(NBLK + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               ram_enable_q, ram_enable_d;
    logic [15:0]        address_q, address_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   cap_cnt_q, cap_cnt_d;
    logic               rd_pend_q;
    logic [rowSize-1:0] row_q, row_d;
`ifdef DMA_RD_CHECKSUM_EN
    logic [blockSize-1:0] cs_q, cs_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ram_enable_q <= 1'b0;
            address_q    <= '0;
            issue_cnt_q  <= '0;
            cap_cnt_q    <= '0;
            rd_pend_q    <= 1'b0;
            row_q        <= '0;
`ifdef DMA_RD_CHECKSUM_EN
            cs_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ram_enable_q <= ram_enable_d;
            address_q    <= address_d;
            issue_cnt_q  <= issue_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            // RAM returns data one cycle after an enabled address.
            rd_pend_q    <= ram_enable_q;
            row_q        <= row_d;
`ifdef DMA_RD_CHECKSUM_EN
            cs_q         <= cs_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        ram_enable_d = ram_enable_q;
        address_d    = address_q;
        issue_cnt_d  = issue_cnt_q;
        cap_cnt_d    = cap_cnt_q;
        row_d        = row_q;
`ifdef DMA_RD_CHECKSUM_EN
        cs_d         = cs_q;
`endif

        case (state_q)
            IDLE: begin
                if (dma_enable) begin
                    state_d      = ISSUE;
                    ram_enable_d = 1'b1;
                    address_d    = base_address;
                    issue_cnt_d  = CNT_W'(1);
                    cap_cnt_d    = '0;
`ifdef DMA_RD_CHECKSUM_EN
                    cs_d         = '0;
`endif
                end
            end
            ISSUE: begin
                // issue_cnt_q counts addresses already presented, including the current one.
                if (issue_cnt_q == CNT_W'(NBLK)) begin
                    state_d      = DRAIN;
                    ram_enable_d = 1'b0;
                end else begin
                    address_d   = address_q + 16'd1;
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rd_pend_q) begin
            row_d[int'(cap_cnt_q) * blockSize +: blockSize] = ram_data;
            cap_cnt_d = cap_cnt_q + CNT_W'(1);
`ifdef DMA_RD_CHECKSUM_EN
            cs_d = cs_q ^ ram_data;
`endif
        end
    end

    assign ram_enable = ram_enable_q;
    assign write      = 1'b0;
    assign address    = address_q;
    assign row_out    = row_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
`ifdef DMA_RD_CHECKSUM_EN
    assign checksum   = cs_q;
`endif

endmodule

// File: tb/tb_dma_row_reader.sv
// Directed bench for dma_row_reader: a 4-block instance (rowSize=64) and a 1-block instance (rowSize=16)
// share one clock, reset and RAM image.
module tb_dma_row_reader;

    logic clk;
    logic rst;

    logic        en4, ram_en4, write4, busy4, done4;
    logic [15:0] base4, addr4, data4;
    logic [63:0] row4;

    logic        en1, ram_en1, write1, busy1, done1;
    logic [15:0] base1, addr1, data1;
    logic [15:0] row1;

`ifdef DMA_RD_CHECKSUM_EN
    logic [15:0] cs4, cs1;
`endif

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    dma_row_reader #(.blockSize(16), .rowSize(64)) u_dut4 (
        .clk(clk), .rst(rst), .dma_enable(en4), .base_address(base4),
        .ram_enable(ram_en4), .write(write4), .address(addr4), .ram_data(data4),
        .row_out(row4), .busy(busy4),
`ifdef DMA_RD_CHECKSUM_EN
        .checksum(cs4),
`endif
        .done(done4)
    );

    dma_row_reader #(.blockSize(16), .rowSize(16)) u_dut1 (
        .clk(clk), .rst(rst), .dma_enable(en1), .base_address(base1),
        .ram_enable(ram_en1), .write(write1), .address(addr1), .ram_data(data1),
        .row_out(row1), .busy(busy1),
`ifdef DMA_RD_CHECKSUM_EN
        .checksum(cs1),
`endif
        .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data for an enabled address appears the next cycle.
    always @(posedge clk) begin
        if (ram_en4) data4 <= mem[addr4];
        if (ram_en1) data1 <= mem[addr1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full 4-block transfer starting from IDLE; expected row/checksum come from the caller.
    task automatic do_xfer4(input logic [15:0] base, input logic [63:0] exp_row);
        base4 = base;
        en4   = 1'b1;
        tick();
        en4   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("issue_addr", 64'(addr4), 64'(16'(base + 16'(i))));
            chk("issue_ram_en", 64'(ram_en4), 64'(1));
            chk("issue_busy", 64'(busy4), 64'(1));
            chk("issue_done", 64'(done4), 64'(0));
            tick();
        end
        chk("drain_ram_en", 64'(ram_en4), 64'(0));
        chk("drain_busy", 64'(busy4), 64'(1));
        chk("drain_done", 64'(done4), 64'(0));
        tick();
        chk("done_pulse", 64'(done4), 64'(1));
        chk("done_busy", 64'(busy4), 64'(1));
        chk("row_out", row4, exp_row);
`ifdef DMA_RD_CHECKSUM_EN
        chk("checksum", 64'(cs4),
            64'(exp_row[15:0] ^ exp_row[31:16] ^ exp_row[47:32] ^ exp_row[63:48]));
`endif
        chk("write_low", 64'(write4), 64'(0));
        tick();
        chk("post_done", 64'(done4), 64'(0));
        chk("post_busy", 64'(busy4), 64'(0));
        chk("row_hold", row4, exp_row);
    endtask

    initial begin
        rst = 1'b1;
        en4 = 1'b0; base4 = '0;
        en1 = 1'b0; base1 = '0;
        data4 = '0; data1 = '0;
        mem[16'h0010] = 16'h1111; mem[16'h0011] = 16'h2222;
        mem[16'h0012] = 16'h3333; mem[16'h0013] = 16'h4444;
        mem[16'hFFFE] = 16'h5A5A; mem[16'hFFFF] = 16'h6B6B;
        mem[16'h0000] = 16'h7C7C; mem[16'h0001] = 16'h8D8D;
        mem[16'h0020] = 16'hAAAA; mem[16'h0021] = 16'hBBBB;
        mem[16'h0022] = 16'hCCCC; mem[16'h0023] = 16'hDDDD;
        mem[16'h0030] = 16'hDEAD; mem[16'h0031] = 16'hBEEF;
        mem[16'h0032] = 16'hCAFE; mem[16'h0033] = 16'hF00D;
        mem[16'h0005] = 16'hABCD;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ram_en", 64'(ram_en4), 64'(0));
        chk("rst_addr", 64'(addr4), 64'(0));
        chk("rst_row", row4, 64'(0));
        chk("rst_busy", 64'(busy4), 64'(0));
        chk("rst_done", 64'(done4), 64'(0));
        chk("rst_write", 64'(write4), 64'(0));
`ifdef DMA_RD_CHECKSUM_EN
        chk("rst_checksum", 64'(cs4), 64'(0));
`endif

        // Basic transfer
        do_xfer4(16'h0010, 64'h4444_3333_2222_1111);

        // Address wraps modulo 2^16
        do_xfer4(16'hFFFE, 64'h8D8D_7C7C_6B6B_5A5A);

        // dma_enable held high: one transfer per IDLE visit, base changed mid-transfer
        base4 = 16'h0010;
        en4   = 1'b1;
        tick();
        base4 = 16'h0020;
        for (int i = 0; i < 4; i++) begin
            chk("hold_addr", 64'(addr4), 64'(16'h0010 + 16'(i)));
            tick();
        end
        chk("hold_drain_en", 64'(ram_en4), 64'(0));
        tick();
        chk("hold_done", 64'(done4), 64'(1));
        chk("hold_row1", row4, 64'h4444_3333_2222_1111);
        tick();
        chk("hold_idle_busy", 64'(busy4), 64'(0));
        chk("hold_idle_ram_en", 64'(ram_en4), 64'(0));
        tick();
        en4 = 1'b0;
        chk("hold_restart_addr", 64'(addr4), 64'(16'h0020));
        chk("hold_restart_en", 64'(ram_en4), 64'(1));
        chk("hold_row_stable_a", row4, 64'h4444_3333_2222_1111);
        tick();
        chk("hold_row_stable_b", row4, 64'h4444_3333_2222_1111);
        tick();
        chk("hold_first_cap", row4, 64'h4444_3333_2222_AAAA);
        tick();
        tick();
        tick();
        chk("hold_done2", 64'(done4), 64'(1));
        chk("hold_row2", row4, 64'hDDDD_CCCC_BBBB_AAAA);
        tick();

        // Reset during the second ISSUE cycle aborts the transfer
        base4 = 16'h0030;
        en4   = 1'b1;
        tick();
        en4   = 1'b0;
        tick();
        chk("abort_pre_addr", 64'(addr4), 64'(16'h0031));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ram_en", 64'(ram_en4), 64'(0));
        chk("abort_addr", 64'(addr4), 64'(0));
        chk("abort_row", row4, 64'(0));
        chk("abort_busy", 64'(busy4), 64'(0));
        chk("abort_done", 64'(done4), 64'(0));
`ifdef DMA_RD_CHECKSUM_EN
        chk("abort_checksum", 64'(cs4), 64'(0));
`endif
        tick();
        chk("abort_stays_idle", 64'(busy4), 64'(0));
        do_xfer4(16'h0010, 64'h4444_3333_2222_1111);

        // Single-block row
        base1 = 16'h0005;
        en1   = 1'b1;
        tick();
        en1   = 1'b0;
        chk("n1_addr", 64'(addr1), 64'(16'h0005));
        chk("n1_ram_en", 64'(ram_en1), 64'(1));
        chk("n1_busy", 64'(busy1), 64'(1));
        tick();
        chk("n1_drain_en", 64'(ram_en1), 64'(0));
        chk("n1_drain_done", 64'(done1), 64'(0));
        tick();
        chk("n1_done", 64'(done1), 64'(1));
        chk("n1_row", 64'(row1), 64'(16'hABCD));
`ifdef DMA_RD_CHECKSUM_EN
        chk("n1_checksum", 64'(cs1), 64'(16'hABCD));
`endif
        tick();
        chk("n1_post_done", 64'(done1), 64'(0));
        chk("n1_post_busy", 64'(busy1), 64'(0));
        chk("n1_write", 64'(write1), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
